led_fade_driver: RTL and testbench
==================================

Name: led_fade_driver

Overview:
- Sits directly downstream of the 10-bit LED PIO output register and drives the board LEDR pins.
- Treats each PIO bit as a per-LED on/off target.
- Ramps each LED's brightness up or down in discrete steps on a prescaled tick, and renders brightness as PWM capped by a global dimmer.
- Can be bypassed so LEDs snap straight to the PIO pattern.

Parameters:
- NUM_LEDS, 10, number of LED channels; equals the PIO output width.
- PWM_BITS, 4, brightness resolution; MAX = 2^PWM_BITS-1 = 15.
- TICK_DIV, 50000, clk cycles per fade step; 1 kHz at 50 MHz. Legal range is 2 or more.

Ports:
- clk  in  1  system clock, shared with the PIO.
- reset  in  1  synchronous, active-high reset.
- pio_data  in  NUM_LEDS  target pattern, driven by the PIO out_port.
- fade_en  in  1  1 = ramp on ticks; 0 = snap to target.
- bright_max  in  PWM_BITS  global brightness cap.
- led_out  out  NUM_LEDS  PWM-modulated LED drive, registered.
- level_flat  out  NUM_LEDS*PWM_BITS  current per-channel level; channel i at bits [i*PWM_BITS +: PWM_BITS].
- settled  out  1  high when every channel is at its target endpoint, registered.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - pio_q = 0, prescaler = 0, tick = 0, pwm_cnt = 0.
  - All levels = 0.
  - led_out = 0, settled = 1.
- Reset asserted mid-ramp: all of the above are cleared at that edge. There is no carry-over.
- Input register: pio_q <= pio_data every cycle. All target decisions use pio_q.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is high for exactly one cycle, in the cycle after the count reaches TICK_DIV-1.
  - Free-running; unaffected by fade_en.
- Per channel i, target T = pio_q[i], endpoint E = T ? MAX : 0. Level update priority, highest first:
  1. fade_en = 0: level <= E every cycle.
  2. tick = 1 and T = 1 and level < MAX: level + 1.
  3. tick = 1 and T = 0 and level > 0: level - 1.
  4. Otherwise: hold.
- Level rules:
  - Saturating; never wraps.
  - A target toggle mid-ramp reverses direction from the current level on the next tick, with no jump.
  - fade_en falling mid-ramp snaps the level to E on the next edge.
  - fade_en rising starts ramping from the current level.
- PWM:
  - pwm_cnt counts 0..MAX-1 and wraps; period MAX cycles.
  - eff = min(level, bright_max).
  - led_out[i] <= (eff > pwm_cnt).
  - eff = MAX gives constantly on; eff = 0 gives constantly off.
  - Duty cycle = eff/MAX.
- settled <= AND over all channels of (level == E), registered.
- Latency with fade_en = 0 and eff = MAX: pio_data edge → pio_q (+1) → level (+2) → led_out (+3 cycles).
- Full ramp 0→MAX with fade_en = 1 takes MAX ticks = MAX*TICK_DIV cycles, ±1 tick of phase.
- bright_max change: takes effect on the next led_out update. Levels are not affected.

Decomposition:
- Shared package holds:
  - LED_PWM_BITS and LED_MAX_LEVEL constants.
  - Default TICK_DIV.
  - A led_level_t typedef of PWM_BITS width.
- One sub-module, led_fade_channel: holds the level register, the update priority logic, and the endpoint compare.
  - Inputs: clk, reset, target, tick, fade_en.
  - Outputs: level, at_target.
- The top instantiates NUM_LEDS channels plus the shared prescaler, pwm_cnt, min/compare stage, and settled reduction.

Test Plan (bench parameters: TICK_DIV = 4, PWM_BITS = 4, NUM_LEDS = 10):
- Reset: hold reset 3 cycles with pio_data = 0x3FF → led_out = 0, all levels 0, settled = 1. Release; with fade_en = 0, led_out = 0x3FF from cycle 3 onward.
- Snap: fade_en = 0, bright_max = 15, pio_data 0x000→0x155 → level_flat channel 0 = 15 at +2, led_out = 0x155 at +3, settled = 1 at +3.
- Ramp up: fade_en = 1, pio_data 0→0x001 → channel 0 level increments by 1 per tick, reaches 15 after 15 ticks (60±4 cycles). settled is 0 throughout and becomes 1 the cycle after the level reaches 15. Level never exceeds 15.
- Reversal: mid-ramp at level 7, drop pio_data[0] → next tick level 6, then down to 0 with no wrap. Toggle fade_en to 0 at level 3 → level 0 next edge.
- PWM/cap: level 15, bright_max = 5 → led_out[0] high exactly 5 of every 15 cycles. bright_max = 0 → always 0. bright_max = 15 with level 8 → 8/15 duty.
- Reset mid-ramp: assert reset when level = 9 → next edge level 0, led_out 0, prescaler restarts, so the first post-reset tick occurs TICK_DIV cycles after release.

Source files
------------

// File: rtl/led_fade_driver_pkg.sv
// Shared constants and types for the LED fade driver and its per-channel ramp logic.
package led_fade_driver_pkg;

  localparam int LED_PWM_BITS  = 4;
  localparam int LED_MAX_LEVEL = (1 << LED_PWM_BITS) - 1;
  localparam int LED_TICK_DIV  = 50000;

  typedef logic [LED_PWM_BITS-1:0] led_level_t;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level register that ramps toward an on/off endpoint on ticks,
// or snaps to it when fading is disabled.
module led_fade_channel
  import led_fade_driver_pkg::*;
#(
  parameter int PWM_BITS = LED_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target,
  input  logic                tick,
  input  logic                fade_en,
  output logic [PWM_BITS-1:0] level,
  output logic                at_target
);

  localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;

  logic [PWM_BITS-1:0] endpoint;

  assign endpoint  = target ? MAX_LEVEL : '0;
  assign at_target = (level == endpoint);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= '0;
    end else if (!fade_en) begin
      level <= endpoint;
    end else if (tick && target && (level != MAX_LEVEL)) begin
      level <= level + 1'b1;
    end else if (tick && !target && (level != '0)) begin
      level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: registers the PIO pattern, ramps each channel's brightness on a prescaled
// tick and renders it as PWM capped by a global dimmer.
module led_fade_driver
  import led_fade_driver_pkg::*;
#(
  parameter int NUM_LEDS = 10,
  parameter int PWM_BITS = LED_PWM_BITS,
  parameter int TICK_DIV = LED_TICK_DIV
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_LEDS-1:0]          pio_data,
  input  logic                         fade_en,
  input  logic [PWM_BITS-1:0]          bright_max,
  output logic [NUM_LEDS-1:0]          led_out,
  output logic [NUM_LEDS*PWM_BITS-1:0] level_flat,
  output logic                         settled
);

  localparam int                  PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(TICK_DIV - 1);
  // PWM period is MAX cycles, so the counter stops one short of MAX.
  localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [NUM_LEDS-1:0] pio_q;
  logic [NUM_LEDS-1:0] at_target;
  logic [NUM_LEDS-1:0] drive;
  logic [PRE_W-1:0]    prescaler;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pio_q     <= '0;
      prescaler <= '0;
      tick      <= 1'b0;
      pwm_cnt   <= '0;
      led_out   <= '0;
      settled   <= 1'b1;
    end else begin
      pio_q     <= pio_data;
      prescaler <= (prescaler == PRE_LAST) ? '0 : prescaler + 1'b1;
      tick      <= (prescaler == PRE_LAST);
      pwm_cnt   <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      led_out   <= drive;
      settled   <= &at_target;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] eff;

    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .target    (pio_q[i]),
      .tick      (tick),
      .fade_en   (fade_en),
      .level     (level),
      .at_target (at_target[i])
    );

    // The dimmer caps brightness at render time only; the level itself keeps ramping.
    assign eff      = (level < bright_max) ? level : bright_max;
    assign drive[i] = (eff > pwm_cnt);
    assign level_flat[i*PWM_BITS +: PWM_BITS] = level;
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Self-checking bench for led_fade_driver: cycle-count based reference model plus directed
// scenarios with hand-derived expectations, followed by randomized stimulus.
module tb_led_fade_driver;
  import led_fade_driver_pkg::*;

  localparam int N    = 10;
  localparam int PB   = 4;
  localparam int TDIV = 4;
  localparam int MAXL = 15;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    pio_data;
  logic            fade_en;
  logic [PB-1:0]   bright_max;
  logic [N-1:0]    led_out;
  logic [N*PB-1:0] level_flat;
  logic            settled;

  led_fade_driver #(
    .NUM_LEDS (N),
    .PWM_BITS (PB),
    .TICK_DIV (TDIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pio_data   (pio_data),
    .fade_en    (fade_en),
    .bright_max (bright_max),
    .led_out    (led_out),
    .level_flat (level_flat),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: time is counted in edges since reset release. Ticks apply on edges
  // 5, 9, 13, ... and the PWM phase seen before edge n is (n-1) mod MAX.
  led_level_t   m_lvl [N];
  logic [N-1:0] m_pio;
  logic [N-1:0] m_led;
  logic         m_settled;
  bit           m_valid = 0;
  int           n_edge;

  always @(posedge clk) begin
    if (reset) begin
      m_pio = '0; m_led = '0; m_settled = 1'b1; n_edge = 0; m_valid = 1;
      for (int i = 0; i < N; i++) m_lvl[i] = '0;
    end else if (m_valid) begin
      bit tk;
      int pw;
      bit all_ok;
      n_edge++;
      tk = (n_edge > 1) && (n_edge % TDIV == 1);
      pw = (n_edge - 1) % MAXL;
      all_ok = 1;
      for (int i = 0; i < N; i++) begin
        int lv, cap, eff, endp;
        lv   = int'(m_lvl[i]);
        cap  = int'(bright_max);
        eff  = (lv < cap) ? lv : cap;
        endp = m_pio[i] ? MAXL : 0;
        m_led[i] = (eff > pw);
        if (lv != endp) all_ok = 0;
        if (!fade_en) lv = endp;
        else if (tk && m_pio[i] && lv < MAXL) lv = lv + 1;
        else if (tk && !m_pio[i] && lv > 0) lv = lv - 1;
        m_lvl[i] = led_level_t'(lv);
      end
      m_settled = all_ok;
      m_pio = pio_data;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic [N*PB-1:0] exp_flat;
      for (int i = 0; i < N; i++) exp_flat[i*PB +: PB] = m_lvl[i];
      check("model_led_out", 64'(led_out), 64'(m_led));
      check("model_level_flat", 64'(level_flat), 64'(exp_flat));
      check("model_settled", 64'(settled), 64'(m_settled));
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  function automatic int lvl0();
    return int'(level_flat[PB-1:0]);
  endfunction

  // Waits (bounded) until channel 0 reaches the given level; returns cycles waited or -1.
  task automatic wait_lvl0(input int want, input int budget, output int cycles);
    cycles = -1;
    for (int c = 1; c <= budget; c++) begin
      step(1);
      if (lvl0() == want) begin
        cycles = c;
        break;
      end
    end
    if (cycles < 0) check("wait_lvl0_timeout", 64'(lvl0()), 64'(want));
  endtask

  task automatic count_high(input int cycles, output int highs);
    highs = 0;
    for (int c = 0; c < cycles; c++) begin
      step(1);
      if (led_out[0]) highs++;
    end
  endtask

  initial begin
    int cyc, highs, prev, lv;
    bit settled_bad, step_bad;

    reset = 1'b1; pio_data = 10'h3FF; fade_en = 1'b0; bright_max = 4'd15;

    // Reset
    step(3);
    check("reset_led_out", 64'(led_out), 64'h0);
    check("reset_levels", 64'(level_flat), 64'h0);
    check("reset_settled", 64'(settled), 64'h1);
    reset = 1'b0;
    step(2);
    check("release_levels_plus2", 64'(level_flat), 64'hFF_FFFF_FFFF);
    check("release_led_plus2", 64'(led_out), 64'h0);
    step(1);
    check("release_led_plus3", 64'(led_out), 64'h3FF);

    // Snap
    pio_data = '0;
    step(4);
    pio_data = 10'h155;
    step(2);
    check("snap_levels_plus2", 64'(level_flat), 64'h0F_0F0F_0F0F);
    check("snap_led_plus2", 64'(led_out), 64'h0);
    check("snap_settled_plus2", 64'(settled), 64'h0);
    step(1);
    check("snap_led_plus3", 64'(led_out), 64'h155);
    check("snap_settled_plus3", 64'(settled), 64'h1);

    // Ramp up
    pio_data = '0;
    step(4);
    fade_en = 1'b1; pio_data = 10'h001;
    cyc = 0; prev = 0; settled_bad = 0; step_bad = 0;
    while (cyc < 200) begin
      step(1);
      cyc++;
      lv = lvl0();
      if (lv < prev || lv > prev + 1) step_bad = 1;
      if (cyc >= 2 && settled) settled_bad = 1;
      prev = lv;
      if (lv == MAXL) break;
    end
    check("ramp_reached_max", 64'(lvl0()), 64'(MAXL));
    check("ramp_duration_in_window", 64'(cyc >= 56 && cyc <= 64), 64'h1);
    check("ramp_single_steps", 64'(step_bad), 64'h0);
    check("ramp_settled_low", 64'(settled_bad), 64'h0);
    step(1);
    check("ramp_settled_after", 64'(settled), 64'h1);
    step(8);
    check("ramp_holds_max", 64'(lvl0()), 64'(MAXL));

    // Reversal
    fade_en = 1'b0; pio_data = '0;
    step(3);
    fade_en = 1'b1; pio_data = 10'h001;
    wait_lvl0(7, 100, cyc);
    pio_data = '0;
    cyc = 0;
    while (cyc < 10 && lvl0() == 7) begin
      step(1);
      cyc++;
    end
    check("reverse_first_step", 64'(lvl0()), 64'd6);
    wait_lvl0(3, 100, cyc);
    fade_en = 1'b0;
    step(1);
    check("fade_off_snaps_zero", 64'(lvl0()), 64'd0);
    fade_en = 1'b1;
    step(20);
    check("no_wrap_below_zero", 64'(lvl0()), 64'd0);

    // PWM and dimmer cap
    fade_en = 1'b0; pio_data = 10'h001; bright_max = 4'd5;
    step(4);
    count_high(15, highs);
    check("pwm_cap5_duty", 64'(highs), 64'd5);
    bright_max = 4'd0;
    step(2);
    count_high(15, highs);
    check("pwm_cap0_duty", 64'(highs), 64'd0);
    bright_max = 4'd8;
    step(2);
    count_high(15, highs);
    check("pwm_cap8_duty", 64'(highs), 64'd8);
    check("cap_keeps_level", 64'(lvl0()), 64'(MAXL));
    bright_max = 4'd15;
    step(2);
    count_high(15, highs);
    check("pwm_full_duty", 64'(highs), 64'd15);

    // Reset mid-ramp
    pio_data = '0;
    step(3);
    fade_en = 1'b1; pio_data = 10'h001;
    wait_lvl0(9, 100, cyc);
    reset = 1'b1;
    step(1);
    check("midreset_levels", 64'(level_flat), 64'h0);
    check("midreset_led_out", 64'(led_out), 64'h0);
    check("midreset_settled", 64'(settled), 64'h1);
    reset = 1'b0;
    step(4);
    check("post_reset_no_early_tick", 64'(lvl0()), 64'd0);
    step(1);
    check("post_reset_first_tick", 64'(lvl0()), 64'd1);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 24) == 0) pio_data = N'($urandom);
      if ($urandom_range(0, 59) == 0) fade_en = ~fade_en;
      if ($urandom_range(0, 39) == 0) bright_max = PB'($urandom);
    end
    reset = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
